// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and slave FSM state type used by the memory slave.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [1:0] HRESP_OKAY  = 2'd0;
  localparam logic [1:0] HRESP_ERROR = 2'd1;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } slave_state_e;

  // Little-endian byte lanes touched by a transfer of the given size at addr[1:0].
  function automatic logic [3:0] lane_enable(input logic [2:0] size, input logic [1:0] addr);
    case (size)
      HSIZE_BYTE: return 4'b0001 << addr;
      HSIZE_HALF: return addr[1] ? 4'b1100 : 4'b0011;
      default:    return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_mem_slave_ram.sv
// Word-organised RAM with per-byte write enables and an asynchronous read port.
module ahb_mem_slave_ram #(
  parameter int MEM_WORDS = 1024,
  parameter int IDX_BITS  = 10
) (
  input  logic                clk,
  input  logic                we,
  input  logic [3:0]          be,
  input  logic [IDX_BITS-1:0] addr,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata
);

  logic [31:0] mem [MEM_WORDS];

  // Only the enabled lanes change; the others keep their old contents.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB memory slave: transfer FSM, wait-state counter, illegal-access check and
// byte-lane generation in front of a byte-writable word RAM.
module ahb_mem_slave
  import ahb_pkg::*;
#(
  parameter int ADDR_BITS   = 16,
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADYin,
  output logic [31:0] HRDATA,
  output logic [1:0]  HRESP,
  output logic        HREADYout
);

  localparam int IDX_BITS = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [ADDR_BITS-2:0] MEM_LIMIT = (ADDR_BITS-1)'(MEM_WORDS);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES - 1);

  slave_state_e        state;
  logic [3:0]          wait_cnt;
  logic                write_q;
  logic                read_phase;
  logic [3:0]          be_q;
  logic [IDX_BITS-1:0] word_q;
  logic                hready_q;
  logic [1:0]          hresp_q;

  logic        accept;
  logic        size_bad;
  logic        misaligned;
  logic        out_of_range;
  logic        illegal;
  logic        ram_we;
  logic [31:0] ram_rdata;

  // Burst type and the decoder-owned upper address bits play no part here.
  logic unused_inputs;
  assign unused_inputs = ^{HTRANS[0], HBURST, HADDR[31:ADDR_BITS]};

  assign accept       = HSEL && HREADYin && HTRANS[1];
  assign size_bad     = HSIZE > HSIZE_WORD;
  assign misaligned   = ((HSIZE == HSIZE_HALF) && HADDR[0]) ||
                        ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00));
  assign out_of_range = {1'b0, HADDR[ADDR_BITS-1:2]} >= MEM_LIMIT;
  assign illegal      = size_bad || misaligned || out_of_range;

  // Commit happens at the end of the write data phase; reset in that cycle drops it.
  assign ram_we = (state == ST_DATA) && write_q && !HRESET;

  // Transfer FSM; IDLE, DATA and ERR2 are the cycles in which a new transfer may be accepted.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      write_q    <= 1'b0;
      read_phase <= 1'b0;
      be_q       <= '0;
      word_q     <= '0;
      hready_q   <= 1'b1;
      hresp_q    <= HRESP_OKAY;
    end else begin
      case (state)
        ST_WAIT: begin
          if (wait_cnt == '0) begin
            state      <= ST_DATA;
            hready_q   <= 1'b1;
            read_phase <= !write_q;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_ERR1: begin
          state    <= ST_ERR2;
          hready_q <= 1'b1;
          hresp_q  <= HRESP_ERROR;
        end
        default: begin
          if (accept) begin
            write_q <= HWRITE;
            be_q    <= lane_enable(HSIZE, HADDR[1:0]);
            word_q  <= HADDR[IDX_BITS+1:2];
            if (illegal) begin
              state      <= ST_ERR1;
              hready_q   <= 1'b0;
              hresp_q    <= HRESP_ERROR;
              read_phase <= 1'b0;
            end else if (WAIT_STATES > 0) begin
              state      <= ST_WAIT;
              wait_cnt   <= WAIT_LOAD;
              hready_q   <= 1'b0;
              hresp_q    <= HRESP_OKAY;
              read_phase <= 1'b0;
            end else begin
              state      <= ST_DATA;
              hready_q   <= 1'b1;
              hresp_q    <= HRESP_OKAY;
              read_phase <= !HWRITE;
            end
          end else begin
            state      <= ST_IDLE;
            hready_q   <= 1'b1;
            hresp_q    <= HRESP_OKAY;
            read_phase <= 1'b0;
          end
        end
      endcase
    end
  end

  ahb_mem_slave_ram #(
    .MEM_WORDS (MEM_WORDS),
    .IDX_BITS  (IDX_BITS)
  ) u_ram (
    .clk   (HCLK),
    .we    (ram_we),
    .be    (be_q),
    .addr  (word_q),
    .wdata (HWDATA),
    .rdata (ram_rdata)
  );

  assign HRDATA    = read_phase ? ram_rdata : 32'h0;
  assign HRESP     = hresp_q;
  assign HREADYout = hready_q;

endmodule
